uart_rx_fifo: RTL

//  Receive-side byte buffer sitting directly downstream of the UART receiver.
//  - Captures each completed frame and counts framing/sync errors.
//  - Stores bytes in a Depth-entry FIFO.
//  - Presents them to the bus/host side on a valid/ready handshake.
//  - Decouples line-rate frame completion from consumer latency; reports overrun.

---
 rtl/uart_pkg.sv | 5 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/uart_rx_fifo.sv | 65 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;
  typedef logic [7:0] byte_t;
  localparam int DefaultFifoDepth = 8;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extended pointers and synchronous flush.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wrData,
  output logic [Width-1:0]         rdData,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(Depth):0]   count
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [Width-1:0] mem [Depth];

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign valid  = (wrPtr != rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count  = wrPtr - rdPtr;
  assign rdData = valid ? mem[rdPtr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PtrOne;
      if (pop && valid) rdPtr <= rdPtr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr[AW-1:0]] <= wrData;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: frame capture, FIFO, overrun flag and error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int Depth    = DefaultFifoDepth,
  parameter int ErrWidth = 8
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  input  logic                   rxErr,
  output logic [7:0]             data,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(Depth):0] count,
  output logic                   overrun,
  output logic [ErrWidth-1:0]    errCount,
  input  logic                   clearErr,
  input  logic                   flush
);
  localparam logic [ErrWidth-1:0] ErrOne = 1;

  logic  pending;
  logic  full;
  logic  push;
  logic  pop;
  byte_t headByte;

  function automatic logic [ErrWidth-1:0] satInc(input logic [ErrWidth-1:0] v);
    return (&v) ? v : v + ErrOne;
  endfunction

  // rxData settles the cycle after rxDone, so the write waits one cycle.
  assign pop  = valid && ready;
  assign push = pending && (!full || pop);
  assign data = headByte;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pending  <= 1'b0;
      overrun  <= 1'b0;
      errCount <= '0;
    end else begin
      pending <= rxDone;
      if (pending && full && !pop) overrun <= 1'b1;
      else if (clearErr)           overrun <= 1'b0;
      if (rxErr)         errCount <= clearErr ? ErrOne : satInc(errCount);
      else if (clearErr) errCount <= '0;
    end
  end

  sync_fifo #(.Width(8), .Depth(Depth)) uFifo (
    .clk    (clk),
    .nReset (nReset),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wrData (rxData),
    .rdData (headByte),
    .valid  (valid),
    .full   (full),
    .count  (count)
  );
endmodule
